// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-port data memory arbiter.
package dmem_arb_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 32;

  localparam logic REQ_CORE = 1'b0;
  localparam logic REQ_DBG  = 1'b1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RD_WAIT   = 3'd1,
    RMW_MERGE = 3'd2,
    WR_ACK    = 3'd3,
    ERR_ACK   = 3'd4
  } arb_state_t;

endpackage

// File: rtl/dmem_byte_merge.sv
// Combinational byte-lane merge: enabled lanes take new_word, the rest keep old_word.
module dmem_byte_merge #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0]   old_word,
  input  logic [DATA_W-1:0]   new_word,
  input  logic [DATA_W/8-1:0] be,
  output logic [DATA_W-1:0]   merged
);

  for (genvar i = 0; i < DATA_W/8; i++) begin : g_lane
    assign merged[8*i +: 8] = be[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter giving a core and a debug/loader port shared access to a
// single-port, registered-read data memory. Partial stores become read-modify-write.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_we,
  input  logic [31:0]       req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  input  logic [3:0]        req0_be,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  output logic              rsp0_err,

  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_we,
  input  logic [31:0]       req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  input  logic [3:0]        req1_be,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic              rsp1_err,

  output logic [31:0]       mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write_enable,
  output logic              mem_read_enable,
  input  logic [DATA_W-1:0] mem_read_data
);

  arb_state_t        state;
  logic              owner;      // requester that issued the operation in flight
  logic              last_gnt;   // requester granted most recently
  logic [ADDR_W-1:0] lat_widx;
  logic [DATA_W-1:0] lat_wdata;
  logic [3:0]        lat_be;

  logic              gnt0, gnt1, acc;
  logic              sel_we;
  logic [31:0]       sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [3:0]        sel_be;
  logic [ADDR_W-1:0] sel_widx;
  logic              sel_in_range;
  logic [DATA_W-1:0] merged;

  // Round-robin grant: a lone requester wins; on contention the one not served last wins.
  assign gnt0 = (state == IDLE) && req0_valid && (!req1_valid || last_gnt == REQ_DBG);
  assign gnt1 = (state == IDLE) && req1_valid && (!req0_valid || last_gnt == REQ_CORE);
  assign acc  = gnt0 || gnt1;

  assign sel_we       = gnt1 ? req1_we    : req0_we;
  assign sel_addr     = gnt1 ? req1_addr  : req0_addr;
  assign sel_wdata    = gnt1 ? req1_wdata : req0_wdata;
  assign sel_be       = gnt1 ? req1_be    : req0_be;
  assign sel_widx     = sel_addr[ADDR_W+1:2];
  assign sel_in_range = (sel_addr >> (ADDR_W + 2)) == 32'd0;

  dmem_byte_merge #(.DATA_W(DATA_W)) u_merge (
    .old_word (mem_read_data),
    .new_word (lat_wdata),
    .be       (lat_be),
    .merged   (merged)
  );

  // Arbitration FSM: latch the accepted request and sequence its memory phases.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      owner     <= REQ_CORE;
      last_gnt  <= REQ_DBG;
      lat_widx  <= '0;
      lat_wdata <= '0;
      lat_be    <= '0;
    end else begin
      case (state)
        IDLE: if (acc) begin
          owner     <= gnt1;
          last_gnt  <= gnt1;
          lat_widx  <= sel_widx;
          lat_wdata <= sel_wdata;
          lat_be    <= sel_be;
          if (!sel_in_range)                          state <= ERR_ACK;
          else if (!sel_we)                           state <= RD_WAIT;
          else if (sel_be == 4'hF || sel_be == 4'h0)  state <= WR_ACK;
          else                                        state <= RMW_MERGE;
        end
        RMW_MERGE: state <= WR_ACK;
        default:   state <= IDLE;
      endcase
    end
  end

  // Memory port and response drive; everything is forced low while reset is held
  // so an abandoned RMW never reaches the memory.
  always_comb begin
    mem_address      = '0;
    mem_write_data   = '0;
    mem_write_enable = 1'b0;
    mem_read_enable  = 1'b0;
    req0_ready       = 1'b0;
    req1_ready       = 1'b0;
    rsp0_valid       = 1'b0;
    rsp0_rdata       = '0;
    rsp0_err         = 1'b0;
    rsp1_valid       = 1'b0;
    rsp1_rdata       = '0;
    rsp1_err         = 1'b0;
    if (rst_n) begin
      req0_ready = gnt0;
      req1_ready = gnt1;
      case (state)
        IDLE: if (acc && sel_in_range) begin
          if (!sel_we) begin
            mem_read_enable = 1'b1;
            mem_address     = {{(32-ADDR_W){1'b0}}, sel_widx};
          end else if (sel_be == 4'hF) begin
            mem_write_enable = 1'b1;
            mem_address      = {{(32-ADDR_W){1'b0}}, sel_widx};
            mem_write_data   = sel_wdata;
          end else if (sel_be != 4'h0) begin
            mem_read_enable = 1'b1;
            mem_address     = {{(32-ADDR_W){1'b0}}, sel_widx};
          end
        end
        RMW_MERGE: begin
          mem_write_enable = 1'b1;
          mem_address      = {{(32-ADDR_W){1'b0}}, lat_widx};
          mem_write_data   = merged;
        end
        RD_WAIT: begin
          if (owner == REQ_DBG) begin
            rsp1_valid = 1'b1;
            rsp1_rdata = mem_read_data;
          end else begin
            rsp0_valid = 1'b1;
            rsp0_rdata = mem_read_data;
          end
        end
        WR_ACK: begin
          if (owner == REQ_DBG) rsp1_valid = 1'b1;
          else                  rsp0_valid = 1'b1;
        end
        ERR_ACK: begin
          if (owner == REQ_DBG) begin
            rsp1_valid = 1'b1;
            rsp1_err   = 1'b1;
          end else begin
            rsp0_valid = 1'b1;
            rsp0_err   = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
